// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: widths, multicycle
// defaults, FSM state encoding and the load-use hazard predicate.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W          = 5;
  localparam int unsigned CNT_W          = 6;
  localparam int unsigned MUL_CYCLES_DEF = 4;
  localparam int unsigned DIV_CYCLES_DEF = 33;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  // Field order is the bit order used when control words are compared as vectors.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic md_busy;
    logic md_done;
  } pipe_ctrl_t;

  // x0 is never a real producer, so a load targeting it cannot create a hazard.
  function automatic logic load_use(
    input logic             mem_read,
    input logic [REG_W-1:0] rd,
    input logic [REG_W-1:0] rs1,
    input logic             rs1_used,
    input logic [REG_W-1:0] rs2,
    input logic             rs2_used
  );
    return mem_read && (rd != REG_W'(0)) &&
           ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The pipeline side is the
// master; the hazard controller consumes ID/EX status and returns controls.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [REG_W-1:0] ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             ex_md_start;
  logic             ex_md_is_div;

  logic pc_en;
  logic if_id_en;
  logic id_ex_en;
  logic ex_mem_en;
  logic if_id_flush;
  logic id_ex_flush;
  logic md_busy;
  logic md_done;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output ex_rd, ex_mem_read, ex_branch_taken, ex_md_start, ex_md_is_div,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en,
    input  if_id_flush, id_ex_flush, md_busy, md_done
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  ex_rd, ex_mem_read, ex_branch_taken, ex_md_start, ex_md_is_div,
    output pc_en, if_id_en, id_ex_en, ex_mem_en,
    output if_id_flush, id_ex_flush, md_busy, md_done
  );

endinterface

// File: rtl/hazard_ctrl_stall_counter.sv
// Loadable down-counter timing the remaining BUSY cycles of a multicycle op.
// Saturates at zero so a stray decrement can never wrap.
module stall_counter
  import hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != CNT_W'(0))) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_W'(0);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == CNT_W'(0));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, and a full-pipe
// freeze while a multicycle multiply/divide occupies EX.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave hz
);

  md_state_e        state_q;
  md_state_e        state_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             lu_hazard;
  pipe_ctrl_t       ctrl_c;

  // Start cycle already counts as one frozen cycle, so BUSY lasts N-1 cycles.
  assign cnt_load_val = hz.ex_md_is_div ? CNT_W'(DIV_CYCLES - 2)
                                        : CNT_W'(MUL_CYCLES - 2);

  assign lu_hazard = load_use(hz.ex_mem_read, hz.ex_rd,
                              hz.id_rs1, hz.id_rs1_used,
                              hz.id_rs2, hz.id_rs2_used);

  always_comb begin
    state_d            = state_q;
    cnt_load           = 1'b0;
    cnt_dec            = 1'b0;
    ctrl_c             = '0;
    ctrl_c.pc_en       = 1'b1;
    ctrl_c.if_id_en    = 1'b1;
    ctrl_c.id_ex_en    = 1'b1;
    ctrl_c.ex_mem_en   = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        // Branch wins over both multicycle start and load-use.
        if (hz.ex_branch_taken) begin
          ctrl_c.if_id_flush = 1'b1;
          ctrl_c.id_ex_flush = 1'b1;
        end else if (hz.ex_md_start) begin
          ctrl_c.pc_en     = 1'b0;
          ctrl_c.if_id_en  = 1'b0;
          ctrl_c.id_ex_en  = 1'b0;
          ctrl_c.ex_mem_en = 1'b0;
          cnt_load         = 1'b1;
          state_d          = ST_BUSY;
        end else if (lu_hazard) begin
          ctrl_c.pc_en       = 1'b0;
          ctrl_c.if_id_en    = 1'b0;
          ctrl_c.id_ex_flush = 1'b1;
        end
      end

      ST_BUSY: begin
        ctrl_c.pc_en     = 1'b0;
        ctrl_c.if_id_en  = 1'b0;
        ctrl_c.id_ex_en  = 1'b0;
        ctrl_c.ex_mem_en = 1'b0;
        ctrl_c.md_busy   = 1'b1;
        cnt_dec          = 1'b1;
        if (cnt_zero) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        ctrl_c.md_done = 1'b1;
        state_d        = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  stall_counter u_stall_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  assign hz.pc_en       = ctrl_c.pc_en;
  assign hz.if_id_en    = ctrl_c.if_id_en;
  assign hz.id_ex_en    = ctrl_c.id_ex_en;
  assign hz.ex_mem_en   = ctrl_c.ex_mem_en;
  assign hz.if_id_flush = ctrl_c.if_id_flush;
  assign hz.id_ex_flush = ctrl_c.id_ex_flush;
  assign hz.md_busy     = ctrl_c.md_busy;
  assign hz.md_done     = ctrl_c.md_done;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected control words are queued as each
// step is driven and compared on the following falling edge.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int unsigned MULC = 4;
  localparam int unsigned DIVC = 33;

  // Control-word patterns: {pc,ifid,idex,exmem,flush_ifid,flush_idex,busy,done}
  localparam logic [7:0] W_RUN   = 8'b1111_0000;
  localparam logic [7:0] W_LU    = 8'b0011_0100;
  localparam logic [7:0] W_BR    = 8'b1111_1100;
  localparam logic [7:0] W_START = 8'b0000_0000;
  localparam logic [7:0] W_BUSY  = 8'b0000_0010;
  localparam logic [7:0] W_DONE  = 8'b1111_0001;
  localparam logic [7:0] M_ALL   = 8'hFF;
  // md_busy is left unspecified on the start cycle, so it is not compared there.
  localparam logic [7:0] M_START = 8'b1111_1101;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [7:0] exp_q[$];
  logic [7:0] msk_q[$];
  string      tag_q[$];

  hazard_ctrl_if hz();

  hazard_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] observed();
    return {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en,
            hz.if_id_flush, hz.id_ex_flush, hz.md_busy, hz.md_done};
  endfunction

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic mr, input logic br, input logic st,
                        input logic dv);
    hz.id_rs1          = rs1;
    hz.id_rs2          = rs2;
    hz.id_rs1_used     = u1;
    hz.id_rs2_used     = u2;
    hz.ex_rd           = rd;
    hz.ex_mem_read     = mr;
    hz.ex_branch_taken = br;
    hz.ex_md_start     = st;
    hz.ex_md_is_div    = dv;
  endtask

  task automatic idle_in();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_pop();
    logic [7:0] e;
    logic [7:0] m;
    logic [7:0] o;
    string      t;
    e = exp_q.pop_front();
    m = msk_q.pop_front();
    t = tag_q.pop_front();
    o = observed();
    n_vec++;
    assert ((o & m) === (e & m)) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b mask=%b", t, o, e, m);
    end
  endtask

  // Push the expectation, compare at the falling edge, return just after the next rise.
  task automatic step(input string tag, input logic [7:0] e, input logic [7:0] m);
    exp_q.push_back(e);
    msk_q.push_back(m);
    tag_q.push_back(tag);
    @(negedge clk);
    check_pop();
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string tag, input logic [7:0] e);
    exp_q.push_back(e);
    msk_q.push_back(M_ALL);
    tag_q.push_back(tag);
    #1;
    check_pop();
  endtask

  // Full multicycle op: start held throughout BUSY and on DONE, optional branch/load-use noise.
  task automatic md_op(input string tag, input logic dv, input int unsigned n,
                       input logic noise);
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1, dv);
    step({tag, "_start"}, W_START, M_START);
    if (noise) set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, dv);
    for (int i = 1; i < int'(n); i++) begin
      step($sformatf("%s_busy%0d", tag, i), W_BUSY, M_ALL);
    end
    step({tag, "_done"}, W_DONE, M_ALL);
    idle_in();
    step({tag, "_after"}, W_RUN, M_ALL);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle_in();
    #12;
    check_now("reset", W_RUN);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    step("idle", W_RUN, M_ALL);

    // Load x5 in EX, ID reads x5 via rs1
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rs1", W_LU, M_ALL);
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_release", W_RUN, M_ALL);

    set_in(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_x0", W_RUN, M_ALL);
    set_in(5'd3, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rs2_unused", W_RUN, M_ALL);
    set_in(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rs2", W_LU, M_ALL);

    set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    step("br_over_lu", W_BR, M_ALL);
    set_in(5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    step("br_only", W_BR, M_ALL);
    set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1);
    step("br_and_start", W_BR, M_ALL);
    idle_in();
    step("br_no_busy", W_RUN, M_ALL);

    md_op("mul", 1'b0, MULC, 1'b0);
    md_op("div", 1'b1, DIVC, 1'b0);
    md_op("mul_noise", 1'b0, MULC, 1'b1);

    // Divide aborted by reset on its 10th cycle
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("abort_start", W_START, M_START);
    for (int i = 1; i < 9; i++) begin
      step($sformatf("abort_busy%0d", i), W_BUSY, M_ALL);
    end
    idle_in();
    rst_n = 1'b0;
    check_now("abort_in_reset", W_RUN);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++) begin
      step($sformatf("abort_idle%0d", i), W_RUN, M_ALL);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MUL_CYCLES, default 4, giving total EX-stage occupancy of a multiply in cycles (2..63).
REQ-002 The block SHALL have parameter DIV_CYCLES, default 33, giving total EX-stage occupancy of a divide in cycles (2..63).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-004 Ports SHALL be: id_rs1  in  5  ID source reg 1; id_rs2  in  5  ID source reg 2; id_rs1_used  in  1  rs1 read; id_rs2_used  in  1  rs2 read.
REQ-005 Ports SHALL be: ex_rd  in  5  EX dest reg; ex_mem_read  in  1  EX is load; ex_branch_taken  in  1  EX redirect; ex_md_start  in  1  EX holds mul/div; ex_md_is_div  in  1  1=div, 0=mul.
REQ-006 Ports SHALL be: pc_en, if_id_en, id_ex_en, ex_mem_en  out  1  pipeline-register enables; if_id_flush, id_ex_flush  out  1  bubble insert; md_busy  out  1  multicycle op in progress; md_done  out  1  result valid this cycle.

Function
REQ-007 State SHALL be one of IDLE, BUSY, DONE, held in a register; counter cnt is 6 bits.
REQ-008 Load-use hazard SHALL be: ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
REQ-009 In IDLE, with load-use and no branch, outputs SHALL be pc_en=0, if_id_en=0, id_ex_flush=1, others enabled, same cycle (combinational).
REQ-010 In IDLE, ex_branch_taken SHALL give if_id_flush=1, id_ex_flush=1, all enables 1, and SHALL override load-use.
REQ-011 In IDLE, ex_md_start with no branch SHALL move to BUSY next edge, load cnt=(ex_md_is_div?DIV_CYCLES:MUL_CYCLES)-2, and drive pc_en=if_id_en=id_ex_en=ex_mem_en=0 that same cycle.
REQ-012 In BUSY, all four enables SHALL be 0, flushes 0, md_busy=1; cnt decrements each cycle; at cnt==0 next state is DONE.
REQ-013 In DONE, md_done=1, md_busy=0, all enables 1, flushes 0; next state SHALL be IDLE unconditionally.
REQ-014 In BUSY and DONE, ex_md_start, ex_branch_taken and load-use SHALL be ignored.
REQ-015 Total freeze for an op SHALL be exactly N cycles (start cycle + BUSY cycles), N=MUL_CYCLES or DIV_CYCLES, followed by one DONE cycle.
REQ-016 With all inputs inactive in IDLE, outputs SHALL be all enables 1, flushes 0, md_busy=0, md_done=0.
REQ-017 ex_branch_taken and ex_md_start together in IDLE SHALL be treated as branch only (no BUSY entry).

Reset
REQ-018 rst_n low SHALL asynchronously force state=IDLE, cnt=0; outputs then follow REQ-009..REQ-016 for IDLE.
REQ-019 Reset asserted during BUSY SHALL abort the op; first cycle after release SHALL be IDLE with no md_done pulse.

Structure
REQ-020 State encoding (IDLE/BUSY/DONE) and default cycle constants SHALL live in the shared pipeline package.
REQ-021 The down-counter SHALL be a sub-module named stall_counter (load, decrement, zero flag, async active-low reset).
REQ-022 Output logic SHALL be combinational from state, cnt and inputs; only state and cnt are registered.

Verification
REQ-023 Load x5 in EX, ID reads rs1=x5 used -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle (EX not load) all enables 1.
REQ-024 Load x0 in EX, ID reads rs1=x0 -> no stall; load x5 with id_rs2=x5 but id_rs2_used=0 -> no stall.
REQ-025 Branch taken plus load-use same cycle -> if_id_flush=1, id_ex_flush=1, pc_en=1, if_id_en=1.
REQ-026 Mul start (defaults), start held high -> enables 0 for exactly 4 cycles, md_done=1 on 5th, then IDLE; div -> 33 cycles then md_done.
REQ-027 Div start, rst_n pulsed low at cycle 10 -> state IDLE, no md_done, enables 1 after release.
REQ-028 ex_branch_taken asserted during BUSY -> no flush, enables stay 0, freeze length unchanged.
